// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: ALU control codes, ALUOp/funct values, FSM states.
package alu_issue_ctrl_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response signals of the ALU issue controller.
interface alu_issue_if;
  import alu_issue_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b, alu_result, alu_zero, out_ready,
    output in_ready, alu_control, alu_in1, alu_in2, out_valid, out_result, out_zero, out_err
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b, alu_result, alu_zero, out_ready,
    input  in_ready, alu_control, alu_in1, alu_in2, out_valid, out_result, out_zero, out_err
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// ALUOp/funct to 4-bit ALU control decode, with operand-swap and legality flags.
module alu_ctl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o,
  output logic       swap_o,
  output logic       legal_o
);

  always_comb begin
    ctrl_o  = ALU_ADD;
    swap_o  = 1'b0;
    legal_o = 1'b1;
    case (aluop_i)
      ALUOP_MEM: ctrl_o = ALU_ADD;
      ALUOP_BEQ: ctrl_o = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: ctrl_o = ALU_ADD;
          FUNCT_SUB: ctrl_o = ALU_SUB;
          FUNCT_AND: ctrl_o = ALU_AND;
          FUNCT_OR:  ctrl_o = ALU_OR;
          // The ALU evaluates in2 < in1, so swapping yields rs < rt
          FUNCT_SLT: begin
            ctrl_o = ALU_SLT;
            swap_o = 1'b1;
          end
          default:   legal_o = 1'b0;
        endcase
      end
      ALUOP_RSVD: legal_o = 1'b0;
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded operation to a registered ALU, waits out its latency and returns the result.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic             in_ready_q;
  logic [3:0]       ctl_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_zero_q;
  logic             out_err_q;

  logic [3:0]       dec_ctrl_d;
  logic             dec_swap_d;
  logic             dec_legal_d;

  alu_ctl_decode u_decode (
    .aluop_i (bus.in_aluop),
    .funct_i (bus.in_funct),
    .ctrl_o  (dec_ctrl_d),
    .swap_o  (dec_swap_d),
    .legal_o (dec_legal_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      ctl_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && bus.in_valid) begin
            in_ready_q <= 1'b0;
            if (dec_legal_d) begin
              ctl_q   <= dec_ctrl_d;
              in1_q   <= dec_swap_d ? bus.in_b : bus.in_a;
              in2_q   <= dec_swap_d ? bus.in_a : bus.in_b;
              cnt_q   <= CNT_INIT;
              state_q <= ST_EXEC;
            end else begin
              out_valid_q  <= 1'b1;
              out_err_q    <= 1'b1;
              out_result_q <= '0;
              out_zero_q   <= 1'b0;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q == 3'd0) state_q <= ST_CAPT;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        ST_CAPT: begin
          // The ALU leaves zero stale for non-subtract ops
          out_result_q <= bus.alu_result;
          out_zero_q   <= (ctl_q == ALU_SUB) && bus.alu_zero;
          out_err_q    <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.alu_control = ctl_q;
  assign bus.alu_in1     = in1_q;
  assign bus.alu_in2     = in2_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_err     = out_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-stage registered ALU model.
module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_issue_if bus();

  alu_issue_ctrl #(.ALU_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return ($signed(y) < $signed(x)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.alu_result <= alu_f(bus.alu_control, bus.alu_in1, bus.alu_in2);
    bus.alu_zero   <= (alu_f(bus.alu_control, bus.alu_in1, bus.alu_in2) == 32'd0);
  end

  task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    bus.in_aluop = op;
    bus.in_funct = f;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.out_zero} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=0000", {bus.in_ready, bus.out_valid, bus.out_err, bus.out_zero});
    end
    checks++;
    if ({bus.alu_control, bus.alu_in1, bus.alu_in2, bus.out_result} !== 100'd0) begin
      failures++;
      $display("FAIL reset_data ctl=%h in1=%h in2=%h res=%h required=0", bus.alu_control, bus.alu_in1, bus.alu_in2, bus.out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    send(2'b10, 6'b100000, 32'd7, 32'd5);
    checks++;
    if (bus.alu_control !== 4'b0010 || bus.alu_in1 !== 32'd7 || bus.alu_in2 !== 32'd5) begin
      failures++;
      $display("FAIL add_issue ctl=%b in1=%0d in2=%0d required 0010/7/5", bus.alu_control, bus.alu_in1, bus.alu_in2);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_lat0 valid=%b ready=%b required 0/0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_lat1 valid=%b required=0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_lat2 valid=%b required=1", bus.out_valid);
    end
    checks++;
    if (bus.out_result !== 32'd12 || bus.out_zero !== 1'b0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL add_result res=%0d zero=%b err=%b required 12/0/0", bus.out_result, bus.out_zero, bus.out_err);
    end
    consume();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_release valid=%b ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_beq();
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic [31:0] vr [2];
    logic        vz [2];
    va = '{32'h1234, 32'd9};
    vb = '{32'h1234, 32'd4};
    vr = '{32'd0, 32'd5};
    vz = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      send(2'b01, 6'b000000, va[i], vb[i]);
      checks++;
      if (bus.alu_control !== 4'b0110) begin
        failures++;
        $display("FAIL beq_ctl[%0d] got=%b required=0110", i, bus.alu_control);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vr[i] || bus.out_zero !== vz[i]) begin
        failures++;
        $display("FAIL beq_result[%0d] valid=%b res=%h zero=%b required 1/%h/%b", i, bus.out_valid, bus.out_result, bus.out_zero, vr[i], vz[i]);
      end
      consume();
    end
  endtask

  task automatic test_slt();
    logic [31:0] va [2];
    logic [31:0] vb [2];
    logic [31:0] vr [2];
    va = '{32'hFFFF_FFFB, 32'd3};
    vb = '{32'd3, 32'hFFFF_FFFB};
    vr = '{32'd1, 32'd0};
    for (int i = 0; i < 2; i++) begin
      send(2'b10, 6'b101010, va[i], vb[i]);
      checks++;
      if (bus.alu_control !== 4'b0111 || bus.alu_in1 !== vb[i] || bus.alu_in2 !== va[i]) begin
        failures++;
        $display("FAIL slt_issue[%0d] ctl=%b in1=%h in2=%h required 0111/%h/%h", i, bus.alu_control, bus.alu_in1, bus.alu_in2, vb[i], va[i]);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vr[i] || bus.out_zero !== 1'b0) begin
        failures++;
        $display("FAIL slt_result[%0d] valid=%b res=%h zero=%b required 1/%h/0", i, bus.out_valid, bus.out_result, bus.out_zero, vr[i]);
      end
      consume();
    end
  endtask

  task automatic test_illegal();
    logic [1:0] vop [2];
    vop = '{2'b10, 2'b11};
    for (int i = 0; i < 2; i++) begin
      send(vop[i], 6'b000000, 32'hDEAD, 32'hBEEF);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_result !== 32'd0 || bus.out_zero !== 1'b0) begin
        failures++;
        $display("FAIL illegal_resp[%0d] valid=%b err=%b res=%h zero=%b required 1/1/0/0", i, bus.out_valid, bus.out_err, bus.out_result, bus.out_zero);
      end
      checks++;
      if (bus.alu_control !== 4'b0111 || bus.alu_in1 !== 32'hFFFF_FFFB || bus.alu_in2 !== 32'd3) begin
        failures++;
        $display("FAIL illegal_alu_hold[%0d] ctl=%b in1=%h in2=%h required 0111/fffffffb/3", i, bus.alu_control, bus.alu_in1, bus.alu_in2);
      end
      consume();
    end
  endtask

  task automatic test_rtype_mask();
    logic [5:0]  vf [2];
    logic [31:0] vr [2];
    logic [3:0]  vc [2];
    vf = '{6'b100101, 6'b100100};
    vc = '{4'b0001, 4'b0000};
    vr = '{32'h0000_FFFF, 32'd0};
    for (int i = 0; i < 2; i++) begin
      send(2'b10, vf[i], 32'h0000_F0F0, 32'h0000_0F0F);
      checks++;
      if (bus.alu_control !== vc[i]) begin
        failures++;
        $display("FAIL rtype_ctl[%0d] got=%b required=%b", i, bus.alu_control, vc[i]);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== vr[i] || bus.out_zero !== 1'b0) begin
        failures++;
        $display("FAIL rtype_result[%0d] valid=%b res=%h zero=%b required 1/%h/0", i, bus.out_valid, bus.out_result, bus.out_zero, vr[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    send(2'b00, 6'b000000, 32'd100, 32'd23);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.in_aluop = 2'b00;
    bus.in_a     = 32'd1;
    bus.in_b     = 32'd2;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd123 || bus.in_ready !== 1'b0 || bus.out_err !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] valid=%b res=%0d ready=%b err=%b required 1/123/0/0", i, bus.out_valid, bus.out_result, bus.in_ready, bus.out_err);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.alu_in1 !== 32'd100) begin
      failures++;
      $display("FAIL bp_handshake valid=%b ready=%b in1=%0d required 0/1/100", bus.out_valid, bus.in_ready, bus.alu_in1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.alu_in1 !== 32'd1 || bus.alu_in2 !== 32'd2 || bus.alu_control !== 4'b0010) begin
      failures++;
      $display("FAIL bp_second_accept ready=%b in1=%0d in2=%0d ctl=%b required 0/1/2/0010", bus.in_ready, bus.alu_in1, bus.alu_in2, bus.alu_control);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3) begin
      failures++;
      $display("FAIL bp_second_result valid=%b res=%0d required 1/3", bus.out_valid, bus.out_result);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    send(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_err, bus.out_zero, bus.alu_control} !== 8'd0 ||
        bus.alu_in1 !== 32'd0 || bus.alu_in2 !== 32'd0 || bus.out_result !== 32'd0) begin
      failures++;
      $display("FAIL midreset_outputs ready=%b valid=%b ctl=%b in1=%h in2=%h res=%h required all 0",
               bus.in_ready, bus.out_valid, bus.alu_control, bus.alu_in1, bus.alu_in2, bus.out_result);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_FF00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_F000 || bus.out_err !== 1'b0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_and valid=%b res=%h err=%b zero=%b required 1/0000f000/0/0", bus.out_valid, bus.out_result, bus.out_err, bus.out_zero);
    end
    consume();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_aluop  = 2'b00;
    bus.in_funct  = 6'b000000;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_beq();
    test_slt();
    test_illegal();
    test_rtype_mask();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
